bp_io_cmd_splitter: RTL



---
 rtl/bp_io_cmd_splitter_pkg.sv | 32 +++
 rtl/bp_io_cmd_splitter_order_fifo.sv | 66 ++++++
 rtl/bp_io_cmd_splitter.sv | 86 ++++++++
 3 files changed

// File: rtl/bp_io_cmd_splitter_pkg.sv
// Shared types and defaults for the I/O command splitter: message layout,
// aux-device address window and port indices.
package bp_io_cmd_splitter_pkg;

    localparam int PADDR_W = 40;
    localparam int DATA_W  = 64;

    localparam logic [PADDR_W-1:0] IO_DEV1_BASE = PADDR_W'('h0020_0000);
    localparam logic [PADDR_W-1:0] IO_DEV1_MASK = PADDR_W'('hFFF0_0000);

    typedef enum logic [0:0] {
        E_IO_PORT_HOST = 1'b0,
        E_IO_PORT_AUX  = 1'b1
    } io_port_e;

    typedef enum logic [3:0] {
        E_MEM_RD = 4'h0,
        E_MEM_WR = 4'h1
    } mem_msg_type_e;

    typedef struct packed {
        mem_msg_type_e      msg_type;
        logic [2:0]         size;
        logic [PADDR_W-1:0] addr;
    } mem_msg_header_s;

    typedef struct packed {
        mem_msg_header_s   header;
        logic [DATA_W-1:0] data;
    } bp_cce_mem_msg_s;

endpackage

// File: rtl/bp_io_cmd_splitter_order_fifo.sv
// Small circular FIFO remembering which port owes each outstanding response.
// Any depth >= 2; pointers wrap explicitly so non-power-of-two depths work.
module bp_io_cmd_splitter_order_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = $clog2(els_p + 1);

    logic [els_p-1:0][width_p-1:0] mem_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (cnt_q != CNT_W'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_comb begin
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        v_i |-> ready_o);

endmodule

// File: rtl/bp_io_cmd_splitter.sv
// Routes one I/O command stream to host (port 0) or aux (port 1) by address,
// and returns responses in command order through a single response register.
module bp_io_cmd_splitter
    import bp_io_cmd_splitter_pkg::*;
#(
    parameter logic [PADDR_W-1:0] dev1_base_p   = IO_DEV1_BASE,
    parameter logic [PADDR_W-1:0] dev1_mask_p   = IO_DEV1_MASK,
    parameter int                 outstanding_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  bp_cce_mem_msg_s       io_cmd_i,
    input  logic                  io_cmd_v_i,
    output logic                  io_cmd_ready_o,
    output bp_cce_mem_msg_s       io_resp_o,
    output logic                  io_resp_v_o,
    input  logic                  io_resp_yumi_i,
    output bp_cce_mem_msg_s [1:0] tgt_cmd_o,
    output logic [1:0]            tgt_cmd_v_o,
    input  logic [1:0]            tgt_cmd_ready_i,
    input  bp_cce_mem_msg_s [1:0] tgt_resp_i,
    input  logic [1:0]            tgt_resp_v_i,
    output logic [1:0]            tgt_resp_yumi_o
);

    logic            sel;
    logic            cmd_open, push;
    logic            fifo_ready, fifo_v, capture;
    logic [0:0]      head;
    bp_cce_mem_msg_s resp_q, resp_d;
    logic            resp_v_q, resp_v_d;

    assign sel          = ((io_cmd_i.header.addr & dev1_mask_p) == dev1_base_p);
    assign tgt_cmd_o[0] = io_cmd_i;
    assign tgt_cmd_o[1] = io_cmd_i;

    // Acceptance looks only at the registered full flag so a same-cycle pop
    // never opens a combinational path from response side to command side.
    assign cmd_open       = reset_n_i & fifo_ready;
    assign io_cmd_ready_o = tgt_cmd_ready_i[sel] & cmd_open;
    assign push           = io_cmd_v_i & io_cmd_ready_o;

    assign capture = fifo_v & tgt_resp_v_i[head] & (~resp_v_q | io_resp_yumi_i);

    always_comb begin
        tgt_cmd_v_o          = '0;
        tgt_cmd_v_o[sel]     = io_cmd_v_i & cmd_open;
        tgt_resp_yumi_o      = '0;
        tgt_resp_yumi_o[head] = capture;
        resp_d               = capture ? tgt_resp_i[head] : resp_q;
        resp_v_d             = capture | (resp_v_q & ~io_resp_yumi_i);
    end

    bp_io_cmd_splitter_order_fifo #(
        .els_p   (outstanding_p),
        .width_p (1)
    ) u_order_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (push),
        .data_i    (sel),
        .ready_o   (fifo_ready),
        .v_o       (fifo_v),
        .data_o    (head),
        .yumi_i    (capture)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_q   <= '0;
            resp_v_q <= 1'b0;
        end else begin
            resp_q   <= resp_d;
            resp_v_q <= resp_v_d;
        end
    end

    assign io_resp_o   = resp_q;
    assign io_resp_v_o = resp_v_q;

    a_resp_without_cmd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !fifo_v |-> (tgt_resp_v_i == 2'b00));
    a_yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        io_resp_yumi_i |-> resp_v_q);

endmodule
